// File: rtl/hbridge_deadtime_guard.sv
// hbridge_deadtime_guard: shoot-through-safe H-bridge command guard with dead-time and latched estop
module hbridge_deadtime_guard #(
  parameter int DEADTIME_CYCLES = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_in3,
  input  logic       cmd_in4,
  input  logic       cmd_enb,
  input  logic       estop,
  output logic       motor_in3,
  output logic       motor_in4,
  output logic       motor_enb,
  output logic [1:0] dir_state,
  output logic       busy,
  output logic       fault,
  output logic       illegal_cmd
);
  localparam int CW = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEADTIME_CYCLES - 1);
  typedef enum logic [2:0] {COAST, FWD, REV, DEAD, ESTOP} state_t;
  state_t state_q, state_d, cmd_st;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic in3_q, in4_q, enb_q, busy_q, fault_q, ill_q;
  logic estop_s, fwd_c, rev_c;
  assign estop_s = sync_q[SYNC_STAGES-1];
  assign fwd_c = cmd_in3 & ~cmd_in4;
  assign rev_c = ~cmd_in3 & cmd_in4;
  assign cmd_st = fwd_c ? FWD : rev_c ? REV : COAST;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (estop_s) state_d = ESTOP;
    else case (state_q)
      COAST: state_d = cmd_st;
      FWD: if (!fwd_c) begin
        state_d = DEAD;
        cnt_d = RELOAD;
      end
      REV: if (!rev_c) begin
        state_d = DEAD;
        cnt_d = RELOAD;
      end
      DEAD: if (cnt_q == '0) state_d = cmd_st;
            else cnt_d = cnt_q - 1'b1;
      // re-arming requires an explicit stop, then a full dead-time
      ESTOP: if (cmd_st == COAST) begin
        state_d = DEAD;
        cnt_d = RELOAD;
      end
      default: state_d = COAST;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COAST;
      cnt_q <= '0;
      sync_q <= '0;
      in3_q <= 1'b0;
      in4_q <= 1'b0;
      enb_q <= 1'b0;
      busy_q <= 1'b0;
      fault_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sync_q <= {sync_q[SYNC_STAGES-2:0], estop};
      in3_q <= state_d == FWD;
      in4_q <= state_d == REV;
      enb_q <= (state_d == FWD || state_d == REV) & cmd_enb;
      busy_q <= state_d == DEAD;
      fault_q <= state_d == ESTOP;
      ill_q <= ill_q | (cmd_in3 & cmd_in4);
    end
  end
  assign motor_in3 = in3_q;
  assign motor_in4 = in4_q;
  assign motor_enb = enb_q;
  assign dir_state = {in3_q, in4_q};
  assign busy = busy_q;
  assign fault = fault_q;
  assign illegal_cmd = ill_q;
endmodule

// File: tb/tb_hbridge_deadtime_guard.sv
// tb_hbridge_deadtime_guard: directed test-plan steps plus random traffic against a timestamp-based reference model
module tb_hbridge_deadtime_guard;
  localparam int D = 4;
  localparam int S = 2;
  localparam int M_CO = 0, M_F = 1, M_R = 2, M_D = 3, M_E = 4;
  logic clk = 1'b0, rst, cmd_in3, cmd_in4, cmd_enb, estop;
  logic motor_in3, motor_in4, motor_enb, busy, fault, illegal_cmd;
  logic [1:0] dir_state;
  int n_cmp = 0, n_bad = 0;
  int mode = M_CO, cyc = 0, dead_end = 0;
  bit ill = 0, enb_m = 0;
  bit es_hist[$];
  logic [7:0] obs;
  hbridge_deadtime_guard #(.DEADTIME_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .cmd_in3(cmd_in3), .cmd_in4(cmd_in4), .cmd_enb(cmd_enb),
    .estop(estop), .motor_in3(motor_in3), .motor_in4(motor_in4), .motor_enb(motor_enb),
    .dir_state(dir_state), .busy(busy), .fault(fault), .illegal_cmd(illegal_cmd)
  );
  always #5 clk = ~clk;
  assign obs = {motor_in3, motor_in4, motor_enb, dir_state, busy, fault, illegal_cmd};
  function automatic logic [7:0] expv();
    return {mode == M_F, mode == M_R, enb_m, mode == M_F, mode == M_R, mode == M_D, mode == M_E, ill};
  endfunction
  task automatic check(input string tag, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  // model: estop delayed S edges via a queue; dead-time ends at an absolute edge index
  task automatic model(input bit a, b, e, s, r);
    int dir;
    bit es_s;
    cyc++;
    if (r) begin
      mode = M_CO; ill = 0; enb_m = 0;
      es_hist.delete();
      repeat (S) es_hist.push_back(1'b0);
      return;
    end
    ill |= a & b;
    es_s = es_hist.pop_front();
    es_hist.push_back(s);
    dir = (a && !b) ? M_F : (!a && b) ? M_R : M_CO;
    if (es_s) mode = M_E;
    else if (mode == M_CO) mode = dir;
    else if (mode == M_F || mode == M_R) begin
      if (dir != mode) begin mode = M_D; dead_end = cyc + D; end
    end else if (mode == M_D) begin
      if (cyc == dead_end) mode = dir;
    end else if (dir == M_CO) begin
      mode = M_D; dead_end = cyc + D;
    end
    enb_m = (mode == M_F || mode == M_R) && e;
  endtask
  task automatic step(input bit a, b, e, s, r, input string tag);
    cmd_in3 = a; cmd_in4 = b; cmd_enb = e; estop = s; rst = r;
    @(posedge clk);
    model(a, b, e, s, r);
    #1;
    check(tag, expv());
    n_cmp++;
    assert (!(motor_in3 && motor_in4)) else begin
      n_bad++;
      $error("FAIL shoot_through_%s observed=%b%b expected=not 11", tag, motor_in3, motor_in4);
    end
  endtask
  initial begin
    bit a, b, e, s, r;
    repeat (S) es_hist.push_back(1'b0);
    cmd_in3 = 0; cmd_in4 = 0; cmd_enb = 0; estop = 0; rst = 1;
    step(0, 0, 0, 0, 1, "reset");
    check("reset_const", 8'b00000000);
    step(1, 0, 1, 0, 0, "t1_fwd");
    check("t1_fwd_const", 8'b10110000);
    step(1, 0, 0, 0, 0, "t1_enb0");
    check("t1_enb0_const", 8'b10010000);
    step(1, 0, 1, 0, 0, "t1_enb1");
    for (int i = 0; i < D; i++) begin
      step(0, 1, 1, 0, 0, "t2_dead");
      check("t2_dead_const", 8'b00000100);
    end
    step(0, 1, 1, 0, 0, "t2_rev");
    check("t2_rev_const", 8'b01101000);
    step(0, 0, 1, 0, 0, "t3_dead");
    step(0, 0, 1, 0, 0, "t3_dead");
    step(1, 0, 1, 0, 0, "t3_dead");
    step(1, 0, 1, 0, 0, "t3_dead");
    check("t3_still_dead", 8'b00000100);
    step(1, 0, 1, 0, 0, "t3_fwd");
    check("t3_fwd_const", 8'b10110000);
    step(1, 0, 1, 1, 0, "t4_estop");
    step(1, 0, 1, 0, 0, "t4_estop");
    step(1, 0, 1, 0, 0, "t4_estop");
    check("t4_fault_const", 8'b00000010);
    repeat (3) step(1, 0, 1, 0, 0, "t4_hold");
    check("t4_hold_const", 8'b00000010);
    for (int i = 0; i < D; i++) step(0, 0, 1, 0, 0, "t4_dead");
    check("t4_dead_const", 8'b00000100);
    step(0, 0, 1, 0, 0, "t4_coast");
    check("t4_coast_const", 8'b00000000);
    step(1, 1, 1, 0, 0, "t5_illegal");
    check("t5_illegal_const", 8'b00000001);
    step(1, 0, 1, 0, 0, "t5_fwd");
    check("t5_fwd_const", 8'b10110001);
    step(0, 0, 0, 0, 0, "t6_dead");
    step(0, 0, 0, 0, 0, "t6_dead");
    step(0, 0, 0, 0, 1, "t6_rst");
    check("t6_rst_const", 8'b00000000);
    step(0, 1, 1, 0, 0, "t6_rev");
    check("t6_rev_const", 8'b01101000);
    a = 0; b = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) {a, b} = 2'($urandom_range(0, 3));
      e = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 59) == 0;
      r = $urandom_range(0, 399) == 0;
      step(a, b, e, s, r, "rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
